// File: rtl/tile_palette_bank_pkg.sv
// rtl/tile_palette_bank_pkg.sv - shared types, default parameters and reset palette for tile_palette_bank
package tile_palette_bank_pkg;

  localparam int IDX_W_DEF        = 4;
  localparam int NUM_BANKS_DEF    = 4;
  localparam int CH_W_DEF         = 4;
  localparam int FLASH_FRAMES_DEF = 16;

  // Index loaded with blue at reset; every other entry comes up green.
  localparam int BLUE_IDX = 1;

  typedef struct packed {
    logic [CH_W_DEF-1:0] r;
    logic [CH_W_DEF-1:0] g;
    logic [CH_W_DEF-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLUE  = '{r: '0, g: '0, b: '1};
  localparam rgb_t RGB_GREEN = '{r: '0, g: '1, b: '0};

  function automatic logic reset_is_blue(input int idx);
    return idx == BLUE_IDX;
  endfunction

endpackage

// File: rtl/tile_palette_bank_if.sv
// rtl/tile_palette_bank_if.sv - pixel lookup, palette write and colour output bundle
interface tile_palette_bank_if
  import tile_palette_bank_pkg::*;
#(
  parameter int IDX_W     = IDX_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int CH_W      = CH_W_DEF
) ();

  logic                         pix_valid;
  logic [IDX_W-1:0]             index;
  logic                         wr_en;
  logic [$clog2(NUM_BANKS)-1:0] wr_bank;
  logic [IDX_W-1:0]             wr_idx;
  logic [3*CH_W-1:0]            wr_rgb;
  logic [CH_W-1:0]              red;
  logic [CH_W-1:0]              green;
  logic [CH_W-1:0]              blue;
  logic                         out_valid;
  logic                         transparent;

  modport master (
    output pix_valid, index, wr_en, wr_bank, wr_idx, wr_rgb,
    input  red, green, blue, out_valid, transparent
  );

  modport slave (
    input  pix_valid, index, wr_en, wr_bank, wr_idx, wr_rgb,
    output red, green, blue, out_valid, transparent
  );

endinterface

// File: rtl/tile_palette_bank_palette_regfile.sv
// rtl/tile_palette_bank_palette_regfile.sv - flop-based palette store, one write and one async read port
module palette_regfile
  import tile_palette_bank_pkg::*;
#(
  parameter int IDX_W     = IDX_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF,
  parameter int CH_W      = CH_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_BANKS)-1:0] wr_bank,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [3*CH_W-1:0]            wr_rgb,
  input  logic [$clog2(NUM_BANKS)-1:0] rd_bank,
  input  logic [IDX_W-1:0]             rd_idx,
  output logic [3*CH_W-1:0]            rd_rgb
);

  localparam int ENTRIES = 2**IDX_W;
  localparam logic [3*CH_W-1:0] BLUE  = {{(2*CH_W){1'b0}}, {CH_W{1'b1}}};
  localparam logic [3*CH_W-1:0] GREEN = {{CH_W{1'b0}}, {CH_W{1'b1}}, {CH_W{1'b0}}};

  logic [3*CH_W-1:0] mem [NUM_BANKS][ENTRIES];

  // Reset dominates, so a write coinciding with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int i = 0; i < ENTRIES; i++) begin
          mem[b][i] <= reset_is_blue(i) ? BLUE : GREEN;
        end
      end
    end else if (wr_en) begin
      mem[wr_bank][wr_idx] <= wr_rgb;
    end
  end

  assign rd_rgb = mem[rd_bank][rd_idx];

endmodule

// File: rtl/tile_palette_bank.sv
// rtl/tile_palette_bank.sv - banked palette lookup with frame-synchronous bank switch and index flashing
module tile_palette_bank
  import tile_palette_bank_pkg::*;
#(
  parameter int IDX_W        = IDX_W_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter int CH_W         = CH_W_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_start,
  input  logic [$clog2(NUM_BANKS)-1:0] bank_req,
  input  logic                         flash_en,
  input  logic [IDX_W-1:0]             flash_idx,
  output logic [$clog2(NUM_BANKS)-1:0] active_bank,
  tile_palette_bank_if.slave           bus
);

  localparam int FC_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FLASH_FRAMES - 1);

  logic [FC_W-1:0]   frame_cnt;
  logic              flash_phase;
  logic [3*CH_W-1:0] rd_rgb;
  logic [3*CH_W-1:0] sel_rgb;
  logic              hit;
  logic              blank;

  palette_regfile #(
    .IDX_W     (IDX_W),
    .NUM_BANKS (NUM_BANKS),
    .CH_W      (CH_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_bank (bus.wr_bank),
    .wr_idx  (bus.wr_idx),
    .wr_rgb  (bus.wr_rgb),
    .rd_bank (active_bank),
    .rd_idx  (bus.index),
    .rd_rgb  (rd_rgb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_bank <= '0;
    end else if (frame_start) begin
      active_bank <= bank_req;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (!flash_en) begin
      frame_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FC_LAST) begin
        frame_cnt   <= '0;
        flash_phase <= ~flash_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // A write landing on the entry being displayed this cycle is forwarded.
  always_comb begin
    hit     = bus.wr_en && (bus.wr_bank == active_bank) && (bus.wr_idx == bus.index);
    sel_rgb = hit ? bus.wr_rgb : rd_rgb;
    blank   = flash_en && flash_phase && (bus.index == flash_idx);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.red         <= '0;
      bus.green       <= '0;
      bus.blue        <= '0;
      bus.out_valid   <= 1'b0;
      bus.transparent <= 1'b0;
    end else begin
      bus.out_valid   <= bus.pix_valid;
      bus.transparent <= bus.pix_valid && (bus.index == '0);
      if (bus.pix_valid && !blank) begin
        bus.red   <= sel_rgb[3*CH_W-1 -: CH_W];
        bus.green <= sel_rgb[2*CH_W-1 -: CH_W];
        bus.blue  <= sel_rgb[CH_W-1 -: CH_W];
      end else begin
        bus.red   <= '0;
        bus.green <= '0;
        bus.blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_tile_palette_bank.sv
// tb/tb_tile_palette_bank.sv - scoreboard bench for tile_palette_bank
module tb_tile_palette_bank;
  import tile_palette_bank_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic [1:0] bank_req = 2'd0;
  logic       flash_en = 1'b0;
  logic [3:0] flash_idx = 4'd0;
  logic [1:0] active_bank;

  tile_palette_bank_if #(.IDX_W(4), .NUM_BANKS(4), .CH_W(4)) bus ();

  tile_palette_bank #(
    .IDX_W        (4),
    .NUM_BANKS    (4),
    .CH_W         (4),
    .FLASH_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .bank_req    (bank_req),
    .flash_en    (flash_en),
    .flash_idx   (flash_idx),
    .active_bank (active_bank),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic       v;
    logic       t;
    rgb_t       rgb;
    logic [1:0] bank;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   tag = 0;

  function automatic void chk(input string name, input int id,
                              input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s step%0d: got %h want %h", name, id, got, want);
    end
  endfunction

  initial begin : monitor
    exp_t e;
    @(negedge clk);
    forever begin
      @(posedge clk or posedge rst);
      #1;
      if (sb.size() == 0) begin
        chk("idle_out_valid", -1, 16'(bus.out_valid), 16'd0);
      end else begin
        e = sb.pop_front();
        chk("out_valid",   e.tag, 16'(bus.out_valid), 16'(e.v));
        chk("transparent", e.tag, 16'(bus.transparent), 16'(e.t));
        chk("rgb",         e.tag, 16'({bus.red, bus.green, bus.blue}), 16'(e.rgb));
        chk("active_bank", e.tag, 16'(active_bank), 16'(e.bank));
      end
    end
  end

  task automatic push(input logic ev, input logic et, input logic [11:0] erg,
                      input logic [1:0] eb);
    exp_t e;
    e.tag  = tag;
    e.v    = ev;
    e.t    = et;
    e.rgb  = erg;
    e.bank = eb;
    tag++;
    sb.push_back(e);
  endtask

  task automatic step(input logic pv, input logic [3:0] idx, input logic fs,
                      input logic we, input logic [1:0] wb, input logic [3:0] wi,
                      input logic [11:0] wd, input logic ev, input logic et,
                      input logic [11:0] erg, input logic [1:0] eb);
    bus.pix_valid = pv;
    bus.index     = idx;
    frame_start   = fs;
    bus.wr_en     = we;
    bus.wr_bank   = wb;
    bus.wr_idx    = wi;
    bus.wr_rgb    = wd;
    push(ev, et, erg, eb);
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [11:0] erg, input logic et,
                    input logic [1:0] eb);
    step(1'b1, idx, 1'b0, 1'b0, 2'd0, 4'd0, 12'h000, 1'b1, et, erg, eb);
  endtask

  task automatic idle(input logic fs, input logic [1:0] eb);
    step(1'b0, 4'd0, fs, 1'b0, 2'd0, 4'd0, 12'h000, 1'b0, 1'b0, 12'h000, eb);
  endtask

  initial begin : driver
    @(negedge clk);
    // Held in reset: outputs and bank stay zero.
    step(1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 4'd0, 12'h000, 1'b0, 1'b0, 12'h000, 2'd0);
    step(1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 4'd0, 12'h000, 1'b0, 1'b0, 12'h000, 2'd0);
    rst = 1'b0;
    rd(4'd1,  12'h00F, 1'b0, 2'd0);
    rd(4'd5,  12'h0F0, 1'b0, 2'd0);
    rd(4'd0,  12'h0F0, 1'b1, 2'd0);
    rd(4'd15, 12'h0F0, 1'b0, 2'd0);

    // Fill bank 2 while bank 0 is displayed, then switch at frame_start.
    step(1'b1, 4'd3, 1'b0, 1'b1, 2'd2, 4'd3, 12'hA5C, 1'b1, 1'b0, 12'h0F0, 2'd0);
    bank_req = 2'd2;
    rd(4'd3, 12'h0F0, 1'b0, 2'd0);
    rd(4'd3, 12'h0F0, 1'b0, 2'd0);
    idle(1'b1, 2'd2);
    rd(4'd3, 12'hA5C, 1'b0, 2'd2);
    step(1'b1, 4'd3, 1'b0, 1'b1, 2'd0, 4'd3, 12'h777, 1'b1, 1'b0, 12'hA5C, 2'd2);
    rd(4'd3, 12'hA5C, 1'b0, 2'd2);

    // Write-first bypass on the active bank.
    step(1'b1, 4'd7, 1'b0, 1'b1, 2'd2, 4'd7, 12'h123, 1'b1, 1'b0, 12'h123, 2'd2);
    rd(4'd7, 12'h123, 1'b0, 2'd2);

    // Three invalid cycles.
    idle(1'b0, 2'd2);
    idle(1'b0, 2'd2);
    idle(1'b0, 2'd2);
    rd(4'd1, 12'h00F, 1'b0, 2'd2);

    // Flashing index 2 with two frames per half-period.
    step(1'b0, 4'd0, 1'b0, 1'b1, 2'd2, 4'd2, 12'h3C9, 1'b0, 1'b0, 12'h000, 2'd2);
    flash_en  = 1'b1;
    flash_idx = 4'd2;
    rd(4'd2, 12'h3C9, 1'b0, 2'd2);
    rd(4'd0, 12'h0F0, 1'b1, 2'd2);
    idle(1'b1, 2'd2);
    rd(4'd2, 12'h3C9, 1'b0, 2'd2);
    rd(4'd0, 12'h0F0, 1'b1, 2'd2);
    idle(1'b1, 2'd2);
    rd(4'd2, 12'h000, 1'b0, 2'd2);
    rd(4'd0, 12'h0F0, 1'b1, 2'd2);
    idle(1'b1, 2'd2);
    rd(4'd2, 12'h000, 1'b0, 2'd2);
    idle(1'b1, 2'd2);
    rd(4'd2, 12'h3C9, 1'b0, 2'd2);
    idle(1'b1, 2'd2);
    rd(4'd2, 12'h3C9, 1'b0, 2'd2);
    idle(1'b1, 2'd2);
    rd(4'd2, 12'h000, 1'b0, 2'd2);
    flash_en = 1'b0;
    rd(4'd2, 12'h3C9, 1'b0, 2'd2);
    flash_en = 1'b1;
    rd(4'd2, 12'h3C9, 1'b0, 2'd2);
    flash_en = 1'b0;

    // Reset arrives mid-cycle while a write to bank 0 idx 1 is pending.
    bus.pix_valid = 1'b1;
    bus.index     = 4'd5;
    frame_start   = 1'b0;
    bus.wr_en     = 1'b1;
    bus.wr_bank   = 2'd0;
    bus.wr_idx    = 4'd1;
    bus.wr_rgb    = 12'hABC;
    push(1'b0, 1'b0, 12'h000, 2'd0);
    push(1'b0, 1'b0, 12'h000, 2'd0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rd(4'd1, 12'h00F, 1'b0, 2'd0);
    rd(4'd5, 12'h0F0, 1'b0, 2'd0);
    rd(4'd3, 12'h0F0, 1'b0, 2'd0);
    idle(1'b1, 2'd2);
    rd(4'd3, 12'h0F0, 1'b0, 2'd2);
    idle(1'b0, 2'd2);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_palette_bank.md
TILE_PALETTE_BANK -- requirements
Module: tile_palette_bank

Interface
REQ-001 SHALL have parameter IDX_W, default 4, palette index width (2**IDX_W entries per bank).
REQ-002 SHALL have parameter NUM_BANKS, default 4, number of palettes (power of two, >=2).
REQ-003 SHALL have parameter CH_W, default 4, bits per colour channel.
REQ-004 SHALL have parameter FLASH_FRAMES, default 16, frames per flash half-period (>=1).
REQ-005 Clk  input  1  system clock; all state is updated on the rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 frame_start  input  1  one-cycle pulse at the start of each frame.
REQ-008 bank_req  input  $clog2(NUM_BANKS)  requested display bank; takes effect at the next frame_start.
REQ-009 pix_valid  input  1  index qualifier.
REQ-010 index  input  IDX_W  pixel palette index.
REQ-011 wr_en / wr_bank / wr_idx / wr_rgb  input  1 / $clog2(NUM_BANKS) / IDX_W / 3*CH_W  palette write port; wr_rgb is packed {R,G,B}.
REQ-012 flash_en / flash_idx  input  1 / IDX_W  enables blinking of a single index.
REQ-013 red, green, blue  output  CH_W each  registered colour.
REQ-014 out_valid / transparent  output  1 / 1  registered qualifiers.
REQ-015 active_bank  output  $clog2(NUM_BANKS)  bank currently used for display.

Function
REQ-016 Lookup SHALL have 1-cycle latency: pix_valid/index at edge N drive red/green/blue, out_valid and transparent after edge N+1.
REQ-017 When pix_valid=0, out_valid SHALL be 0 and the colour outputs SHALL be 0.
REQ-018 transparent SHALL be 1 iff out_valid=1 and the registered index equals 0.
REQ-019 A write SHALL update entry [wr_bank][wr_idx] at the edge where wr_en=1.
REQ-020 When a same-cycle read and write hit the same bank/index, the lookup SHALL return the new wr_rgb (write-first bypass).
REQ-021 active_bank SHALL load bank_req only on a cycle with frame_start=1; a bank_req change mid-frame SHALL NOT affect output until then.
REQ-022 The frame counter SHALL increment on each frame_start and wrap from FLASH_FRAMES-1 to 0; flash_phase SHALL toggle on that wrap.
REQ-023 With flash_en=1, flash_phase=1 and index==flash_idx, the output colour SHALL be 0 (black) and transparent SHALL be unaffected.
REQ-024 flash_en=0 SHALL clear the frame counter and flash_phase synchronously.
REQ-025 Writes to the non-active bank SHALL never disturb display output (double-buffer use).

Reset
REQ-026 Reset SHALL force outputs red/green/blue=0, out_valid=0, transparent=0, active_bank=0, frame counter=0 and flash_phase=0.
REQ-027 Reset SHALL load every bank with entry 1 = {0,max,0}... no: entry 1 = blue {0,0,max} and every other entry = green {0,max,0}, where max = all-ones CH_W.
REQ-028 Reset asserted mid-frame or mid-write SHALL discard the write; the entry SHALL hold its reset value.

Structure
REQ-029 A shared package SHALL hold the rgb_t packed struct {r,g,b}, the reset-default constants and the default parameter values.
REQ-030 The palette storage SHALL be a single sub-module, palette_regfile (1 write port, 1 read port, reset-loadable), instantiated once.
REQ-031 Palette storage SHALL be flip-flops, not inferred block RAM, because of the reset-load requirement.

Verification
REQ-032 After Reset, index=1 in bank 0 -> next cycle {0,0,F}, out_valid=1; index=5 -> {0,F,0}.
REQ-033 Write bank 2 idx 3 = 12'hA5C; bank_req=2 mid-frame -> idx 3 still reads {0,F,0} until frame_start, then reads {A,5,C}; active_bank=2.
REQ-034 Same-cycle write active bank idx 7 = 12'h123 with read idx 7 -> output 12'h123 next cycle.
REQ-035 flash_en=1, flash_idx=2, FLASH_FRAMES=2: frames 0-1 idx 2 shows stored colour, frames 2-3 show 0, frames 4-5 show stored colour; idx 0 -> transparent=1 throughout.
REQ-036 Assert Reset during a wr_en cycle -> all outputs 0 immediately; entry retains its default; afterwards idx 1 -> {0,0,F}.
REQ-037 pix_valid=0 for 3 cycles -> out_valid=0 and colour=0 for exactly those 3 output cycles.
